sonar_scheduler: RTL and testbench
==================================

SONAR_SCHEDULER -- requirements
Module: sonar_scheduler

Interface
REQ-001 Parameter N_SENSORS, default 4: number of ultrasonic sensors served round-robin (2..8).
REQ-002 Parameter TRIG_CYCLES, default 500: trigger pulse width in clock cycles (10 us at 50 MHz).
REQ-003 Parameter SLOT_CYCLES, default 100000: slot length per sensor in cycles, counted from trigger rise.
REQ-004 Parameter RISE_TIMEOUT, default 50000: maximum cycles from trigger fall to echo rise.
REQ-005 Parameter CNT_W, default 18: echo width counter and result width.
REQ-006 CLOCK_50  input  1  sole clock; all logic on rising edge.
REQ-007 RESET_N  input  1  asynchronous, active-low reset.
REQ-008 enable  input  1  level; 1 = run the scan, 0 = stop after the current slot.
REQ-009 echo  input  N_SENSORS  asynchronous echo lines, bit i from sensor i.
REQ-010 trig  output  N_SENSORS  trigger lines, bit i to sensor i; registered.
REQ-011 dist_data  output  CNT_W  measured echo high-time in cycles.
REQ-012 dist_id  output  3  index of the sensor the result belongs to.
REQ-013 dist_valid  output  1  single-cycle strobe qualifying dist_data, dist_id, dist_timeout.
REQ-014 dist_timeout  output  1  1 = no echo or echo not finished within slot.
REQ-015 busy  output  1  1 whenever the state is not IDLE.

Function
REQ-016 Each echo bit SHALL pass a 2-flop synchronizer; edges are detected on the synchronized value against its previous-cycle copy.
REQ-017 States: IDLE, TRIG, WAIT_RISE, MEASURE, REPORT, GAP.
REQ-018 IDLE: with enable=1, go to TRIG on the next cycle, sensor index cur = last served + 1 mod N_SENSORS (0 after reset).
REQ-019 TRIG: trig[cur]=1 for exactly TRIG_CYCLES cycles; all other trig bits 0 at all times; slot timer starts at 0 on the first TRIG cycle.
REQ-020 WAIT_RISE: on synchronized rising edge of echo[cur] clear width counter, go to MEASURE; if RISE_TIMEOUT cycles elapse first, go to REPORT with timeout=1, data=0.
REQ-021 An echo[cur] already high on WAIT_RISE entry SHALL NOT count; a low-to-high edge is required.
REQ-022 MEASURE: width counter increments each cycle echo[cur] stays high, saturating at all-ones (no wrap); on falling edge go to REPORT with timeout=0.
REQ-023 If the slot timer reaches SLOT_CYCLES-1 in WAIT_RISE or MEASURE, go to REPORT with timeout=1; data = current counter value (0 from WAIT_RISE).
REQ-024 REPORT: dist_valid=1 for exactly one cycle with dist_id=cur; dist_data/dist_id/dist_timeout hold until the next REPORT.
REQ-025 GAP: wait until slot timer = SLOT_CYCLES-1, then TRIG for cur+1 mod N_SENSORS if enable=1, else IDLE.
REQ-026 Slot-to-slot period SHALL be exactly SLOT_CYCLES cycles while enable stays 1; echo lines of non-selected sensors are ignored.
REQ-027 enable falling mid-slot SHALL NOT abort the slot; the result is reported, then IDLE.
REQ-028 Echo falling edge and slot end in the same cycle: report timeout=0 with the counted value.

Reset
REQ-029 RESET_N=0 SHALL immediately force: state IDLE, trig=0, dist_valid=0, dist_timeout=0, dist_data=0, dist_id=0, busy=0, counters and synchronizers 0, next sensor 0.
REQ-030 Reset mid-slot SHALL drop trig within the reset assertion and produce no dist_valid for the aborted slot.

Verification
REQ-031 enable=1, sensor 0 echo rises 1000 cycles after trig fall, high 2900 cycles -> trig[0] high 500 cycles, dist_valid once, dist_id=0, dist_data=2900 (+/-0 after sync latency), timeout=0.
REQ-032 N_SENSORS=4, all echoes valid -> trig rises on sensors 0,1,2,3,0 at cycles 0,100000,200000,300000,400000 after start.
REQ-033 Sensor 2 echo never rises -> REPORT with dist_id=2, dist_data=0, dist_timeout=1 at RISE_TIMEOUT after trig fall; scan continues to sensor 3.
REQ-034 CNT_W=8, echo high 1000 cycles -> dist_data=255, timeout=0; echo still high at slot end -> timeout=1.
REQ-035 enable dropped during sensor 1 MEASURE -> sensor 1 result reported, busy falls, no trig on sensor 2; RESET_N pulsed mid-TRIG -> trig=0 at once, no dist_valid.

Source files
------------

// File: rtl/sonar_scheduler.sv
// sonar_scheduler
// Round-robin ultrasonic ranging scheduler. Each sensor gets a fixed slot of
// SLOT_CYCLES clocks measured from its trigger rise: a TRIG_CYCLES trigger
// pulse, a wait for the echo rising edge (bounded by RISE_TIMEOUT), an echo
// high-time measurement, and a single-cycle result strobe.
//
// Ports
//   CLOCK_50     : sole clock, rising edge
//   RESET_N      : asynchronous active-low reset
//   enable       : 1 = keep scanning, 0 = finish current slot then idle
//   echo[i]      : asynchronous echo line from sensor i
//   trig[i]      : registered trigger line to sensor i
//   dist_data    : echo high time in clocks (saturating)
//   dist_id      : sensor index of the result
//   dist_valid   : one-cycle strobe qualifying dist_data/dist_id/dist_timeout
//   dist_timeout : 1 = no echo edge, or echo not finished within the slot
//   busy         : 1 whenever the FSM is not in IDLE
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | scan stopped, waiting for enable
// TRIG      | trig[cur] high, TRIG_CYCLES cycles
// WAIT_RISE | waiting for a low-to-high edge on echo[cur]
// MEASURE   | counting echo[cur] high cycles
// REPORT    | dist_valid high for this cycle
// GAP       | idle until the slot timer expires

module sonar_scheduler #(
    parameter int N_SENSORS    = 4,
    parameter int TRIG_CYCLES  = 500,
    parameter int SLOT_CYCLES  = 100000,
    parameter int RISE_TIMEOUT = 50000,
    parameter int CNT_W        = 18
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET_N,
    input  logic                 enable,
    input  logic [N_SENSORS-1:0] echo,
    output logic [N_SENSORS-1:0] trig,
    output logic [CNT_W-1:0]     dist_data,
    output logic [2:0]           dist_id,
    output logic                 dist_valid,
    output logic                 dist_timeout,
    output logic                 busy
);

    localparam int SLOT_W  = $clog2(SLOT_CYCLES + 1);
    localparam int AUX_MAX = (TRIG_CYCLES > RISE_TIMEOUT) ? TRIG_CYCLES : RISE_TIMEOUT;
    localparam int AUX_W   = $clog2(AUX_MAX + 1);

    localparam logic [SLOT_W-1:0] SLOT_LOAD = SLOT_W'(SLOT_CYCLES - 1);
    localparam logic [AUX_W-1:0]  TRIG_LOAD = AUX_W'(TRIG_CYCLES - 1);
    localparam logic [AUX_W-1:0]  RISE_LOAD = AUX_W'(RISE_TIMEOUT - 1);
    localparam logic [2:0]        LAST_ID   = 3'(N_SENSORS - 1);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        REPORT,
        GAP
    } state_t;

    state_t               state;
    logic [2:0]           cur;
    logic [2:0]           nxt;
    logic [SLOT_W-1:0]    slot_rem;
    logic [AUX_W-1:0]     aux_rem;
    logic [CNT_W-1:0]     width;

    logic [N_SENSORS-1:0] echo_s1;
    logic [N_SENSORS-1:0] echo_s2;
    logic [N_SENSORS-1:0] echo_d;
    logic [7:0]           echo_now_pad;
    logic [7:0]           echo_old_pad;
    logic                 echo_rise;
    logic                 echo_fall;
    logic                 slot_last;
    logic                 slot_end_next;
    logic                 launch;
    logic                 stop;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            echo_s1 <= '0;
            echo_s2 <= '0;
            echo_d  <= '0;
        end else begin
            echo_s1 <= echo;
            echo_s2 <= echo_s1;
            echo_d  <= echo_s2;
        end
    end

    // Pad to 8 bits so the 3-bit sensor index always selects a real bit.
    always_comb begin
        echo_now_pad                = '0;
        echo_old_pad                = '0;
        echo_now_pad[N_SENSORS-1:0] = echo_s2;
        echo_old_pad[N_SENSORS-1:0] = echo_d;
    end

    assign echo_rise     = echo_now_pad[cur] & ~echo_old_pad[cur];
    assign echo_fall     = ~echo_now_pad[cur] & echo_old_pad[cur];

    // slot_rem counts down from SLOT_CYCLES-1 at trigger rise; zero marks the
    // final cycle of the slot. A slot-end abort is taken one cycle early so
    // the REPORT cycle lands on that final cycle and the next trigger can
    // still start exactly SLOT_CYCLES after the previous one.
    assign slot_last     = (slot_rem == '0);
    assign slot_end_next = (slot_rem == SLOT_W'(1));

    assign launch = enable &&
                    ((state == IDLE) || (((state == REPORT) || (state == GAP)) && slot_last));
    assign stop   = !enable && ((state == REPORT) || (state == GAP)) && slot_last;

    assign busy   = (state != IDLE);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= IDLE;
            cur          <= '0;
            nxt          <= '0;
            slot_rem     <= '0;
            aux_rem      <= '0;
            width        <= '0;
            trig         <= '0;
            dist_data    <= '0;
            dist_id      <= '0;
            dist_valid   <= 1'b0;
            dist_timeout <= 1'b0;
        end else begin
            dist_valid <= 1'b0;
            if (!slot_last) begin
                slot_rem <= slot_rem - SLOT_W'(1);
            end

            case (state)
                IDLE: ;
                TRIG: begin
                    if (aux_rem == '0) begin
                        state   <= WAIT_RISE;
                        trig    <= '0;
                        aux_rem <= RISE_LOAD;
                    end else begin
                        aux_rem <= aux_rem - AUX_W'(1);
                    end
                end
                WAIT_RISE: begin
                    if (echo_rise) begin
                        // The edge cycle is itself the first high cycle.
                        state <= MEASURE;
                        width <= CNT_W'(1);
                    end else if (slot_end_next || (aux_rem == '0)) begin
                        state        <= REPORT;
                        dist_valid   <= 1'b1;
                        dist_id      <= cur;
                        dist_data    <= '0;
                        dist_timeout <= 1'b1;
                    end else begin
                        aux_rem <= aux_rem - AUX_W'(1);
                    end
                end
                MEASURE: begin
                    if (echo_fall || slot_end_next) begin
                        // A falling edge wins over a coincident slot end.
                        state        <= REPORT;
                        dist_valid   <= 1'b1;
                        dist_id      <= cur;
                        dist_data    <= width;
                        dist_timeout <= !echo_fall;
                    end else if (width != '1) begin
                        width <= width + CNT_W'(1);
                    end
                end
                REPORT:  state <= GAP;
                GAP:     ;
                default: state <= IDLE;
            endcase

            if (launch) begin
                state    <= TRIG;
                cur      <= nxt;
                nxt      <= (nxt == LAST_ID) ? 3'd0 : nxt + 3'd1;
                trig     <= N_SENSORS'(1) << nxt;
                slot_rem <= SLOT_LOAD;
                aux_rem  <= TRIG_LOAD;
            end else if (stop) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_sonar_scheduler.sv
// Testbench for sonar_scheduler with scaled-down timing:
// N_SENSORS=4, TRIG_CYCLES=5, SLOT_CYCLES=400, RISE_TIMEOUT=60, CNT_W=8.
// A stimulus process plays one directed row per slot, acting as the sensor
// addressed by the trigger, and pushes the hand-computed result; a monitor
// pops and compares on every dist_valid.

module tb_sonar_scheduler;

    localparam int NS   = 4;
    localparam int TRIG = 5;
    localparam int SLOT = 400;
    localparam int RISE = 60;
    localparam int CW   = 8;

    logic          CLOCK_50;
    logic          RESET_N;
    logic          enable;
    logic [NS-1:0] echo;
    logic [NS-1:0] trig;
    logic [CW-1:0] dist_data;
    logic [2:0]    dist_id;
    logic          dist_valid;
    logic          dist_timeout;
    logic          busy;

    sonar_scheduler #(
        .N_SENSORS   (NS),
        .TRIG_CYCLES (TRIG),
        .SLOT_CYCLES (SLOT),
        .RISE_TIMEOUT(RISE),
        .CNT_W       (CW)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET_N     (RESET_N),
        .enable      (enable),
        .echo        (echo),
        .trig        (trig),
        .dist_data   (dist_data),
        .dist_id     (dist_id),
        .dist_valid  (dist_valid),
        .dist_timeout(dist_timeout),
        .busy        (busy)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    typedef struct {
        int id;
        int data;
        int to;
        int lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests     = 0;
    int   failed    = 0;
    int   last_rise = 0;
    int   prev_rise = 0;

    // Directed slot table. mode: 0 echo pulse, 1 no echo, 2 echo already high
    // during TRIG. lat = cycles from trig rise to the dist_valid cycle
    // (8 + delay + high time for a normal pulse).
    //                  0    1    2    3    4    5    6    7    8    9   10
    int t_id[11]   = '{ 0,   1,   2,   3,   0,   1,   2,   3,   0,   1,   0};
    int t_d[11]    = '{10,  20,   0,   5,  10,  10,   0,  30,  10,  10,  10};
    int t_h[11]    = '{29, 100,   0, 300, 381, 382,   0,  40,  50,  60,  77};
    int t_mode[11] = '{ 0,   0,   1,   0,   0,   0,   2,   0,   0,   0,   0};
    int t_noise[11]= '{-1,   2,  -1,  -1,  -1,  -1,  -1,  -1,  -1,  -1,  -1};
    int t_drop[11] = '{ 0,   0,   0,   0,   0,   0,   0,   0,   0,   1,   1};
    int t_data[11] = '{29, 100,   0, 255, 255, 255,   0,  40,  50,  60,  77};
    int t_to[11]   = '{ 0,   0,   1,   0,   0,   1,   1,   0,   0,   0,   0};
    int t_lat[11]  = '{47, 128,  65, 313, 399, 399,  65,  78,  68,  78,  95};

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_trig(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge CLOCK_50);
            #1;
            if (trig != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 1000; i++) begin
            if (!busy) break;
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic run_slot(input int idx);
        bit   ok;
        int   w;
        int   id;
        exp_t e;
        id = t_id[idx];
        wait_trig(ok);
        check($sformatf("trig_seen_%0d", idx), int'(ok), 1);
        if (!ok) return;
        last_rise = cyc;
        if (idx > 0 && idx < 10) check($sformatf("period_%0d", idx), cyc - prev_rise, SLOT);
        prev_rise = cyc;
        check($sformatf("trig_sel_%0d", idx), int'(trig), 1 << id);
        e.id   = id;
        e.data = t_data[idx];
        e.to   = t_to[idx];
        e.lat  = t_lat[idx];
        sb.push_back(e);

        if (t_mode[idx] == 2) echo[id] = 1'b1;
        w = 1;
        for (int i = 0; i < 100; i++) begin
            @(posedge CLOCK_50);
            #1;
            if (trig == '0) break;
            w++;
        end
        check($sformatf("trig_width_%0d", idx), w, TRIG);

        if (t_mode[idx] == 0) begin
            if (t_noise[idx] >= 0) echo[t_noise[idx]] = 1'b1;
            for (int i = 0; i < t_d[idx]; i++) begin
                if (t_noise[idx] >= 0 && i == t_d[idx] / 2) echo[t_noise[idx]] = 1'b0;
                @(posedge CLOCK_50);
                #1;
            end
            echo[id] = 1'b1;
            for (int i = 0; i < t_h[idx]; i++) begin
                if (t_drop[idx] != 0 && i == 5) enable = 1'b0;
                @(posedge CLOCK_50);
                #1;
            end
            echo[id] = 1'b0;
        end else if (t_mode[idx] == 2) begin
            repeat (100) begin
                @(posedge CLOCK_50);
                #1;
            end
            echo[id] = 1'b0;
        end
    endtask

    always @(negedge CLOCK_50) begin
        if (RESET_N && dist_valid) begin
            if (sb.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_valid: got dist_valid=1 for id %0d, expected no result", dist_id);
            end else begin
                mon_e = sb.pop_front();
                check("dist_id", int'(dist_id), mon_e.id);
                check("dist_data", int'(dist_data), mon_e.data);
                check("dist_timeout", int'(dist_timeout), mon_e.to);
                check("report_latency", cyc - last_rise, mon_e.lat);
            end
        end
    end

    initial begin
        #(20 * 30000);
        $display("FAIL watchdog: got simulation still running, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  rises;
        bit  ok;
        RESET_N = 1'b0;
        enable  = 1'b0;
        echo    = '0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("rst_trig", int'(trig), 0);
        check("rst_valid", int'(dist_valid), 0);
        check("rst_data", int'(dist_data), 0);
        check("rst_id", int'(dist_id), 0);
        check("rst_timeout", int'(dist_timeout), 0);
        check("rst_busy", int'(busy), 0);
        @(negedge CLOCK_50) RESET_N = 1'b1;
        @(negedge CLOCK_50) enable = 1'b1;

        for (int s = 0; s < 10; s++) run_slot(s);

        wait_idle();
        check("busy_fall", int'(busy), 0);
        rises = 0;
        repeat (500) begin
            @(posedge CLOCK_50);
            #1;
            if (trig != '0) rises++;
        end
        check("no_trig_after_stop", rises, 0);
        check("sb_drain_stop", sb.size(), 0);

        enable = 1'b1;
        wait_trig(ok);
        check("restart_seen", int'(ok), 1);
        check("restart_sensor", int'(trig), 4);
        @(posedge CLOCK_50);
        #5 RESET_N = 1'b0;
        #1;
        check("midtrig_rst_trig", int'(trig), 0);
        check("midtrig_rst_busy", int'(busy), 0);
        check("midtrig_rst_valid", int'(dist_valid), 0);
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50) RESET_N = 1'b1;

        run_slot(10);
        wait_idle();
        check("busy_fall_final", int'(busy), 0);
        repeat (20) @(posedge CLOCK_50);
        #1;
        check("sb_drain_final", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
